seg7_scan_ctrl: RTL and testbench

Multiplexed-display scan controller for a common-anode 7-segment bank of NUM_DIGITS digits. It holds a double-buffered ASCII character store, written over a valid/ready port by the JTAG timer logic. It time-multiplexes one character at a time onto the shared 7-segment encoder and drives the matching active-low digit enable. Tear-free updates are guaranteed by committing the shadow buffer only at frame boundaries.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_char_buf.sv | 50 +++++
 rtl/seg7_scan_ctrl.sv | 119 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [7:0] CHAR_BLANK = 8'h20;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_char_buf.sv
// Double-buffered character store: writes land in shadow, a copy publishes
// shadow to active, and the read port shows what active will hold after this cycle.
module seg7_char_buf
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [idx_w(NUM_DIGITS)-1:0]    wr_addr,
  input  logic [7:0]                      wr_char,
  input  logic                            copy,
  input  logic [idx_w(NUM_DIGITS)-1:0]    rd_idx,
  output logic [7:0]                      rd_char
);

  localparam int AW    = idx_w(NUM_DIGITS);
  localparam int DEPTH = 2 ** AW;
  // Addresses beyond the bank complete the handshake but are dropped.
  localparam logic [DEPTH-1:0] ADDR_OK = {DEPTH{1'b1}} >> (DEPTH - NUM_DIGITS);

  logic [7:0] shadow [NUM_DIGITS];
  logic [7:0] active [NUM_DIGITS];
  logic       addr_ok;

  assign addr_ok = ADDR_OK[wr_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= CHAR_BLANK;
        active[i] <= CHAR_BLANK;
      end
    end else begin
      if (wr_en && addr_ok) begin
        shadow[wr_addr] <= wr_char;
      end
      if (copy) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // During a copy the register edge publishes shadow, so forward it.
  assign rd_char = copy ? shadow[rd_idx] : active[rd_idx];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a common-anode 7-segment bank: time-multiplexes digits,
// inserts anti-ghosting gaps and publishes buffered text only at frame boundaries.
//
//   state    | meaning
//   ST_BLANK | all digits off for BLANK_CYCLES; exit advances digit_idx
//   ST_SHOW  | digit_idx lit for REFRESH_DIV cycles
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [idx_w(NUM_DIGITS)-1:0]  wr_addr,
  input  logic [7:0]                    wr_char,
  input  logic                          commit,
  output logic                          commit_pending,
  input  logic                          blank,
  output logic [7:0]                    char_out,
  output logic [NUM_DIGITS-1:0]         digit_sel_n,
  output logic                          frame_start
);

  localparam int AW   = idx_w(NUM_DIGITS);
  localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TW   = idx_w(TMAX);

  localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_DIGITS - 1);

  scan_state_e           state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [AW-1:0]         digit_idx, idx_nxt, idx_adv;
  logic                  first_pass;
  logic                  show_done, blank_done, boundary, copy;
  logic                  wr_en, pending_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [7:0]            rd_char;

  assign wr_en = wr_valid && wr_ready;

  always_comb begin
    show_done  = (state == ST_SHOW)  && (timer == SHOW_LAST);
    blank_done = (state == ST_BLANK) && (timer == BLANK_LAST);
    // The blank that follows reset lands on digit 0 rather than advancing.
    idx_adv    = (first_pass || (digit_idx == LAST_IDX)) ? '0 : digit_idx + 1'b1;
    boundary   = blank_done && (idx_adv == '0);
    copy       = boundary && commit_pending;

    state_nxt = state;
    timer_nxt = timer + 1'b1;
    idx_nxt   = digit_idx;
    if (show_done) begin
      state_nxt = ST_BLANK;
      timer_nxt = '0;
    end else if (blank_done) begin
      state_nxt = ST_SHOW;
      timer_nxt = '0;
      idx_nxt   = idx_adv;
    end

    pending_nxt = commit_pending;
    if (copy) begin
      pending_nxt = 1'b0;
    end else if (commit && !commit_pending) begin
      pending_nxt = 1'b1;
    end

    sel_nxt = '1;
    if ((state_nxt == ST_SHOW) && !blank) begin
      sel_nxt[idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_BLANK;
      timer          <= '0;
      digit_idx      <= '0;
      first_pass     <= 1'b1;
      commit_pending <= 1'b0;
      wr_ready       <= 1'b1;
      frame_start    <= 1'b0;
      digit_sel_n    <= '1;
      char_out       <= CHAR_BLANK;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      digit_idx      <= idx_nxt;
      first_pass     <= first_pass && !blank_done;
      commit_pending <= pending_nxt;
      wr_ready       <= !pending_nxt;
      frame_start    <= boundary;
      digit_sel_n    <= sel_nxt;
      if (blank_done) begin
        char_out <= rd_char;
      end
    end
  end

  seg7_char_buf #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_char_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .copy    (copy),
    .rd_idx  (idx_adv),
    .rd_char (rd_char)
  );

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a 4-digit bank, 8-cycle digits and 2-cycle gaps.
module tb_seg7_scan_ctrl;

  localparam int NUM_DIGITS   = 4;
  localparam int REFRESH_DIV  = 8;
  localparam int BLANK_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [7:0] wr_char;
  logic       commit;
  logic       commit_pending;
  logic       blank;
  logic [7:0] char_out;
  logic [3:0] digit_sel_n;
  logic       frame_start;

  int n_vec = 0;
  int n_bad = 0;
  int fs_cnt;
  int fs_pos;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .commit         (commit),
    .commit_pending (commit_pending),
    .blank          (blank),
    .char_out       (char_out),
    .digit_sel_n    (digit_sel_n),
    .frame_start    (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_frame(input int max_cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < max_cyc);
    chk("frame_seen", frame_start, 1);
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] ch, input logic with_commit);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_char  = ch;
    commit   = with_commit;
    chk("wr_ready_before_write", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_char  = 8'h00;
    commit   = 1'b0;
    blank    = 1'b0;
    ticks(3);
    chk("rst_sel", digit_sel_n, 4'b1111);
    chk("rst_char", char_out, 8'h20);
    chk("rst_ready", wr_ready, 1);
    chk("rst_pending", commit_pending, 0);
    chk("rst_fs", frame_start, 0);

    // 1: free-running scan with nothing written
    reset = 1'b0;
    tick();
    chk("t1_blank0", digit_sel_n, 4'b1111);
    tick();
    chk("t1_first_lit", digit_sel_n, 4'b1110);
    chk("t1_first_fs", frame_start, 1);
    chk("t1_char", char_out, 8'h20);
    ticks(7);
    chk("t1_show_end", digit_sel_n, 4'b1110);
    tick();
    chk("t1_gap", digit_sel_n, 4'b1111);
    ticks(2);
    chk("t1_digit1", digit_sel_n, 4'b1101);
    chk("t1_no_fs", frame_start, 0);
    ticks(30);
    chk("t1_frame2_fs", frame_start, 1);
    chk("t1_frame2_sel", digit_sel_n, 4'b1110);

    // 2: write "1234", commit mid-frame
    do_write(2'd0, 8'h31, 1'b0);
    do_write(2'd1, 8'h32, 1'b0);
    do_write(2'd2, 8'h33, 1'b0);
    do_write(2'd3, 8'h34, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t2_pending", commit_pending, 1);
    chk("t2_ready_low", wr_ready, 0);
    chk("t2_char_old", char_out, 8'h20);
    wait_frame(60);
    chk("t2_applied", commit_pending, 0);
    chk("t2_ready_back", wr_ready, 1);
    chk("t2_char0", char_out, 8'h31);
    chk("t2_sel0", digit_sel_n, 4'b1110);
    ticks(30);
    chk("t2_char3", char_out, 8'h34);
    chk("t2_sel3", digit_sel_n, 4'b0111);

    // 3: write held off by a pending commit, needs a second commit
    commit = 1'b1;
    tick();
    commit   = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 2'd2;
    wr_char  = 8'h39;
    chk("t3_ready_low", wr_ready, 0);
    wait_frame(60);
    chk("t3_ready_back", wr_ready, 1);
    chk("t3_char0", char_out, 8'h31);
    tick();
    wr_valid = 1'b0;
    ticks(19);
    chk("t3_sel2", digit_sel_n, 4'b1011);
    chk("t3_char2_old", char_out, 8'h33);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_frame(60);
    ticks(20);
    chk("t3_char2_new", char_out, 8'h39);
    chk("t3_sel2_new", digit_sel_n, 4'b1011);

    // 4: blank for 25 cycles
    blank  = 1'b1;
    fs_cnt = 0;
    fs_pos = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk("t4_blank_sel", digit_sel_n, 4'b1111);
      if (frame_start) begin
        fs_cnt++;
        fs_pos = i;
      end
    end
    chk("t4_fs_cnt", fs_cnt, 1);
    chk("t4_fs_pos", fs_pos, 20);
    blank = 1'b0;
    tick();
    chk("t4_resume_sel", digit_sel_n, 4'b1110);
    chk("t4_resume_char", char_out, 8'h31);

    // 5: reset during SHOW of digit 2
    ticks(16);
    chk("t5_pre_sel", digit_sel_n, 4'b1011);
    reset = 1'b1;
    #1;
    chk("t5_async_sel", digit_sel_n, 4'b1111);
    chk("t5_async_char", char_out, 8'h20);
    tick();
    chk("t5_held_sel", digit_sel_n, 4'b1111);
    chk("t5_held_ready", wr_ready, 1);
    reset = 1'b0;
    ticks(2);
    chk("t5_restart_sel", digit_sel_n, 4'b1110);
    chk("t5_restart_fs", frame_start, 1);
    chk("t5_restart_char", char_out, 8'h20);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_frame(60);
    chk("t5_shadow_cleared", char_out, 8'h20);

    // 6: write and commit in the same cycle
    do_write(2'd3, 8'h41, 1'b1);
    chk("t6_pending", commit_pending, 1);
    chk("t6_ready_low", wr_ready, 0);
    wait_frame(60);
    chk("t6_char0", char_out, 8'h20);
    ticks(20);
    chk("t6_char2", char_out, 8'h20);
    ticks(10);
    chk("t6_char3", char_out, 8'h41);
    chk("t6_sel3", digit_sel_n, 4'b0111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
